output_drain_scheduler: RTL and testbench

Round-robin drain controller that sits between NUM_BUFFERS array output buffers and the single shared quantize/activate unit. For each tile it accepts a start command with an expected result count and pops entries from the buffers one per cycle via their consume strobes. It presents each popped entry to the quantizer through a registered valid/ready stage, then signals done once every expected result has been handed off.

---
 rtl/output_drain_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_output_drain_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_scheduler.sv
// Round-robin drain of NUM_BUFFERS output buffers into one shared quantizer.
// Each popped entry lands in a single registered valid/ready slot, and done
// pulses once the expected number of results has been handed off.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; buffers are never consumed here
//   DRAIN  | granting one buffer head per cycle into the output slot
//   FLUSH  | target reached; waiting for the slot to empty and buffers idle
//   DONE   | one-cycle completion pulse, then back to IDLE
module output_drain_scheduler #(
  parameter int NUM_BUFFERS = 4,
  parameter int MAX_N       = 512,
  parameter int N_BITS      = $clog2(MAX_N),
  parameter int CNT_BITS    = $clog2(MAX_N * MAX_N + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [CNT_BITS-1:0]                 expected_count,
  input  logic [NUM_BUFFERS-1:0]              buf_valid,
  input  logic [NUM_BUFFERS-1:0][31:0]        buf_output,
  input  logic [NUM_BUFFERS-1:0][N_BITS-1:0]  buf_row,
  input  logic [NUM_BUFFERS-1:0][N_BITS-1:0]  buf_col,
  input  logic [NUM_BUFFERS-1:0]              buf_idle,
  output logic [NUM_BUFFERS-1:0]              buf_consume,
  output logic                                q_valid,
  output logic [31:0]                         q_output,
  output logic [N_BITS-1:0]                   q_row,
  output logic [N_BITS-1:0]                   q_col,
  input  logic                                q_ready,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_BITS-1:0]                 drained_count
);

  localparam int PTR_BITS = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [PTR_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_BITS-1:0] target_q, target_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] cnt_inc;
  logic                q_valid_q, q_valid_d;
  logic [31:0]         q_output_q, q_output_d;
  logic [N_BITS-1:0]   q_row_q, q_row_d;
  logic [N_BITS-1:0]   q_col_q, q_col_d;

  logic                slot_free;
  logic                grant_any;
  logic                grant;
  logic [PTR_BITS-1:0] grant_idx;
  logic [PTR_BITS-1:0] scan_idx;

  assign slot_free = !q_valid_q || q_ready;
  assign cnt_inc   = cnt_q + CNT_BITS'(1);

  // Round-robin search: scan downward so the closest index to rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_BUFFERS - 1; k >= 0; k--) begin
      scan_idx = PTR_BITS'((int'(rr_ptr_q) + k) % NUM_BUFFERS);
      if (buf_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Reset gates the grant so an aborted tile never pops another entry.
  assign grant = (state_q == S_DRAIN) && slot_free && grant_any && !reset;

  // Datapath next-state: output slot, round-robin pointer, tile counters.
  always_comb begin
    q_valid_d  = q_valid_q;
    q_output_d = q_output_q;
    q_row_d    = q_row_q;
    q_col_d    = q_col_q;
    rr_ptr_d   = rr_ptr_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = expected_count;
          cnt_d    = '0;
        end
      end
      S_DRAIN: begin
        if (grant) begin
          q_valid_d  = 1'b1;
          q_output_d = buf_output[grant_idx];
          q_row_d    = buf_row[grant_idx];
          q_col_d    = buf_col[grant_idx];
          rr_ptr_d   = (grant_idx == PTR_BITS'(NUM_BUFFERS - 1)) ? '0
                                                                 : grant_idx + PTR_BITS'(1);
          cnt_d      = cnt_inc;
        end else if (q_valid_q && q_ready) begin
          q_valid_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (q_valid_q && q_ready) begin
          q_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid_q  <= 1'b0;
      q_output_q <= '0;
      q_row_q    <= '0;
      q_col_q    <= '0;
      rr_ptr_q   <= '0;
      target_q   <= '0;
      cnt_q      <= '0;
    end else begin
      q_valid_q  <= q_valid_d;
      q_output_q <= q_output_d;
      q_row_q    <= q_row_d;
      q_col_q    <= q_col_d;
      rr_ptr_q   <= rr_ptr_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; FLUSH leaves as soon as the slot will be empty next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (expected_count == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (grant && (cnt_inc == target_q)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!q_valid_d && (&buf_idle)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: one-hot pop strobe plus status.
  always_comb begin
    buf_consume = '0;
    if (grant) begin
      buf_consume[grant_idx] = 1'b1;
    end
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign q_valid       = q_valid_q;
  assign q_output      = q_output_q;
  assign q_row         = q_row_q;
  assign q_col         = q_col_q;
  assign drained_count = cnt_q;

endmodule

// File: tb/tb_output_drain_scheduler.sv
// Directed bench for output_drain_scheduler with a small buffer-queue model.
module tb_output_drain_scheduler;

  localparam int NB = 4;
  localparam int NBITS = 9;
  localparam int CBITS = 19;

  logic                        clk;
  logic                        reset;
  logic                        start;
  logic [CBITS-1:0]            expected_count;
  logic [NB-1:0]               buf_valid;
  logic [NB-1:0][31:0]         buf_output;
  logic [NB-1:0][NBITS-1:0]    buf_row;
  logic [NB-1:0][NBITS-1:0]    buf_col;
  logic [NB-1:0]               buf_idle;
  logic [NB-1:0]               buf_consume;
  logic                        q_valid;
  logic [31:0]                 q_output;
  logic [NBITS-1:0]            q_row;
  logic [NBITS-1:0]            q_col;
  logic                        q_ready;
  logic                        busy;
  logic                        done;
  logic [CBITS-1:0]            drained_count;

  output_drain_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .expected_count (expected_count),
    .buf_valid      (buf_valid),
    .buf_output     (buf_output),
    .buf_row        (buf_row),
    .buf_col        (buf_col),
    .buf_idle       (buf_idle),
    .buf_consume    (buf_consume),
    .q_valid        (q_valid),
    .q_output       (q_output),
    .q_row          (q_row),
    .q_col          (q_col),
    .q_ready        (q_ready),
    .busy           (busy),
    .done           (done),
    .drained_count  (drained_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Buffer model: per-buffer entry list with a head pointer popped on consume.
  int bval [NB][8];
  int brow [NB][8];
  int bcol [NB][8];
  int bhead[NB];
  int bcnt [NB];

  // Values applied to the DUT on the next tick.
  logic             start_v = 1'b0;
  logic             reset_v = 1'b1;
  logic             ready_v = 1'b1;
  logic [CBITS-1:0] cnt_v   = '0;

  task automatic apply();
    for (int i = 0; i < NB; i++) begin
      if (bhead[i] < bcnt[i]) begin
        buf_valid[i]  = 1'b1;
        buf_output[i] = 32'(bval[i][bhead[i]]);
        buf_row[i]    = NBITS'(brow[i][bhead[i]]);
        buf_col[i]    = NBITS'(bcol[i][bhead[i]]);
      end else begin
        buf_valid[i]  = 1'b0;
        buf_output[i] = '0;
        buf_row[i]    = '0;
        buf_col[i]    = '0;
      end
      buf_idle[i] = !buf_valid[i];
    end
  endtask

  task automatic tick();
    logic [NB-1:0] c;
    c = buf_consume;
    @(posedge clk);
    for (int i = 0; i < NB; i++) if (c[i] === 1'b1) bhead[i]++;
    #1;
    reset          = reset_v;
    start          = start_v;
    expected_count = cnt_v;
    q_ready        = ready_v;
    apply();
    #1;
  endtask

  task automatic load(input int b, input int n, input int base, input int row, input int col0);
    bhead[b] = 0;
    bcnt[b]  = n;
    for (int j = 0; j < n; j++) begin
      bval[b][j] = base + j;
      brow[b][j] = row;
      bcol[b][j] = col0 + j;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NB; i++) begin
      bhead[i] = 0;
      bcnt[i]  = 0;
    end
  endtask

  task automatic test_reset();
    clear_all();
    load(0, 1, 77, 1, 1);
    reset_v = 1'b1;
    repeat (3) tick();
    n_cmp++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL reset_q_valid got %b want 0", q_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (drained_count !== '0) begin n_err++; $display("FAIL reset_drained got %0d want 0", drained_count); end
    n_cmp++; if (q_output !== 32'd0) begin n_err++; $display("FAIL reset_q_output got %0d want 0", q_output); end
    n_cmp++; if (buf_consume !== 4'b0000) begin n_err++; $display("FAIL reset_consume got %b want 0000", buf_consume); end
    reset_v = 1'b0;
    tick();
    n_cmp++; if (buf_consume !== 4'b0000) begin n_err++; $display("FAIL idle_consume got %b want 0000", buf_consume); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
    clear_all();
    tick();
  endtask

  task automatic test_single_buffer();
    load(0, 4, 10, 0, 0);
    start_v = 1'b1; cnt_v = 19'd4; ready_v = 1'b1;
    tick();
    n_cmp++; if (buf_consume !== 4'b0000) begin n_err++; $display("FAIL single_idle_consume got %b want 0000", buf_consume); end
    start_v = 1'b0;
    tick();
    n_cmp++; if (buf_consume !== 4'b0001) begin n_err++; $display("FAIL single_consume c1 got %b want 0001", buf_consume); end
    n_cmp++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL single_q_valid c1 got %b want 0", q_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy c1 got %b want 1", busy); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (buf_consume !== 4'b0001) begin n_err++; $display("FAIL single_consume c%0d got %b want 0001", k + 1, buf_consume); end
      n_cmp++; if (q_valid !== 1'b1 || q_output !== 32'(10 + k - 1)) begin n_err++; $display("FAIL single_q_output c%0d got v=%b %0d want v=1 %0d", k + 1, q_valid, q_output, 10 + k - 1); end
      n_cmp++; if (q_col !== NBITS'(k - 1) || q_row !== '0) begin n_err++; $display("FAIL single_q_rowcol c%0d got %0d/%0d want 0/%0d", k + 1, q_row, q_col, k - 1); end
    end
    tick();
    n_cmp++; if (buf_consume !== 4'b0000) begin n_err++; $display("FAIL single_flush_consume got %b want 0000", buf_consume); end
    n_cmp++; if (q_valid !== 1'b1 || q_output !== 32'd13 || q_col !== NBITS'(3)) begin n_err++; $display("FAIL single_last got v=%b %0d col %0d want v=1 13 col 3", q_valid, q_output, q_col); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_early got %b want 0", done); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done got %b want 1", done); end
    n_cmp++; if (q_valid !== 1'b0) begin n_err++; $display("FAIL single_q_valid_end got %b want 0", q_valid); end
    n_cmp++; if (drained_count !== 19'd4) begin n_err++; $display("FAIL single_drained got %0d want 4", drained_count); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_after got done=%b busy=%b want 0/0", done, busy); end
    n_cmp++; if (drained_count !== 19'd4) begin n_err++; $display("FAIL single_drained_hold got %0d want 4", drained_count); end
  endtask

  task automatic test_round_robin();
    reset_v = 1'b1; tick();
    reset_v = 1'b0; tick();
    for (int i = 0; i < NB; i++) load(i, 2, 100 * i, i, 0);
    start_v = 1'b1; cnt_v = 19'd8;
    tick();
    start_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++; if (buf_consume !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL rr_grant k%0d got %b want %b", k, buf_consume, 4'(1 << (k % 4))); end
      if (k > 0) begin
        n_cmp++; if (q_output !== 32'(100 * ((k - 1) % 4) + (k - 1) / 4)) begin n_err++; $display("FAIL rr_q_output k%0d got %0d want %0d", k, q_output, 100 * ((k - 1) % 4) + (k - 1) / 4); end
      end
    end
    tick();
    n_cmp++; if (buf_consume !== 4'b0000 || q_output !== 32'd301) begin n_err++; $display("FAIL rr_flush got %b %0d want 0000 301", buf_consume, q_output); end
    tick();
    n_cmp++; if (done !== 1'b1 || drained_count !== 19'd8) begin n_err++; $display("FAIL rr_done got done=%b cnt=%0d want 1/8", done, drained_count); end
    tick();
  endtask

  task automatic test_backpressure();
    load(1, 3, 50, 5, 7);
    start_v = 1'b1; cnt_v = 19'd3; ready_v = 1'b1;
    tick();
    start_v = 1'b0;
    tick();
    n_cmp++; if (buf_consume !== 4'b0010) begin n_err++; $display("FAIL bp_first_grant got %b want 0010", buf_consume); end
    ready_v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (buf_consume !== 4'b0000) begin n_err++; $display("FAIL bp_stall_consume s%0d got %b want 0000", k, buf_consume); end
      n_cmp++; if (q_valid !== 1'b1 || q_output !== 32'd50 || q_row !== NBITS'(5) || q_col !== NBITS'(7)) begin n_err++; $display("FAIL bp_hold s%0d got v=%b %0d r%0d c%0d want v=1 50 r5 c7", k, q_valid, q_output, q_row, q_col); end
    end
    ready_v = 1'b1;
    tick();
    n_cmp++; if (buf_consume !== 4'b0010 || q_output !== 32'd50) begin n_err++; $display("FAIL bp_resume got %b %0d want 0010 50", buf_consume, q_output); end
    tick();
    n_cmp++; if (buf_consume !== 4'b0010 || q_output !== 32'd51) begin n_err++; $display("FAIL bp_third_grant got %b %0d want 0010 51", buf_consume, q_output); end
    tick();
    n_cmp++; if (buf_consume !== 4'b0000 || q_output !== 32'd52 || done !== 1'b0) begin n_err++; $display("FAIL bp_last got %b %0d done=%b want 0000 52 0", buf_consume, q_output, done); end
    tick();
    n_cmp++; if (done !== 1'b1 || drained_count !== 19'd3) begin n_err++; $display("FAIL bp_done got done=%b cnt=%0d want 1/3", done, drained_count); end
    tick();
  endtask

  task automatic test_zero_count();
    load(0, 1, 5, 0, 0);
    start_v = 1'b1; cnt_v = 19'd0;
    tick();
    n_cmp++; if (busy !== 1'b0 || buf_consume !== 4'b0000) begin n_err++; $display("FAIL zero_c0 got busy=%b cons=%b want 0/0000", busy, buf_consume); end
    start_v = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || buf_consume !== 4'b0000) begin n_err++; $display("FAIL zero_c1 got done=%b busy=%b cons=%b want 1/1/0000", done, busy, buf_consume); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || buf_consume !== 4'b0000) begin n_err++; $display("FAIL zero_c2 got done=%b busy=%b cons=%b want 0/0/0000", done, busy, buf_consume); end
    clear_all();
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NB; i++) load(i, 2, 1000 + 10 * i, 0, i);
    start_v = 1'b1; cnt_v = 19'd6;
    tick();
    start_v = 1'b0;
    tick();
    n_cmp++; if (buf_consume !== 4'b0100) begin n_err++; $display("FAIL mid_grant1 got %b want 0100", buf_consume); end
    tick();
    n_cmp++; if (buf_consume !== 4'b1000) begin n_err++; $display("FAIL mid_grant2 got %b want 1000", buf_consume); end
    reset_v = 1'b1;
    tick();
    n_cmp++; if (buf_consume !== 4'b0000) begin n_err++; $display("FAIL mid_reset_consume got %b want 0000", buf_consume); end
    reset_v = 1'b0;
    tick();
    n_cmp++; if (q_valid !== 1'b0 || busy !== 1'b0 || buf_consume !== 4'b0000 || q_output !== 32'd0) begin n_err++; $display("FAIL mid_after_reset got v=%b busy=%b cons=%b out=%0d want 0/0/0000/0", q_valid, busy, buf_consume, q_output); end
    start_v = 1'b1; cnt_v = 19'd2;
    tick();
    start_v = 1'b0;
    tick();
    n_cmp++; if (buf_consume !== 4'b0001) begin n_err++; $display("FAIL mid_restart_g0 got %b want 0001", buf_consume); end
    tick();
    n_cmp++; if (buf_consume !== 4'b0010 || q_output !== 32'd1000) begin n_err++; $display("FAIL mid_restart_g1 got %b %0d want 0010 1000", buf_consume, q_output); end
    for (int i = 0; i < NB; i++) bhead[i] = bcnt[i];
    tick();
    n_cmp++; if (buf_consume !== 4'b0000 || q_output !== 32'd1010) begin n_err++; $display("FAIL mid_restart_flush got %b %0d want 0000 1010", buf_consume, q_output); end
    tick();
    n_cmp++; if (done !== 1'b1 || drained_count !== 19'd2) begin n_err++; $display("FAIL mid_restart_done got done=%b cnt=%0d want 1/2", done, drained_count); end
    clear_all();
    tick();
  endtask

  task automatic test_ignore_start();
    load(3, 5, 200, 3, 0);
    start_v = 1'b1; cnt_v = 19'd2;
    tick();
    start_v = 1'b0;
    tick();
    n_cmp++; if (buf_consume !== 4'b1000) begin n_err++; $display("FAIL ign_grant1 got %b want 1000", buf_consume); end
    start_v = 1'b1; cnt_v = 19'd7;
    tick();
    n_cmp++; if (buf_consume !== 4'b1000) begin n_err++; $display("FAIL ign_grant2 got %b want 1000", buf_consume); end
    start_v = 1'b0;
    tick();
    n_cmp++; if (buf_consume !== 4'b0000 || q_output !== 32'd201) begin n_err++; $display("FAIL ign_flush got %b %0d want 0000 201", buf_consume, q_output); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (buf_consume !== 4'b0000 || q_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL ign_wait w%0d got cons=%b v=%b busy=%b done=%b want 0000/0/1/0", k, buf_consume, q_valid, busy, done); end
    end
    bhead[3] = bcnt[3];
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ign_done_early got %b want 0", done); end
    tick();
    n_cmp++; if (done !== 1'b1 || drained_count !== 19'd2) begin n_err++; $display("FAIL ign_done got done=%b cnt=%0d want 1/2", done, drained_count); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_after got busy=%b want 0", busy); end
  endtask

  initial begin
    clear_all();
    reset = 1'b1; start = 1'b0; expected_count = '0; q_ready = 1'b1;
    apply();
    test_reset();
    test_single_buffer();
    test_round_robin();
    test_backpressure();
    test_zero_count();
    test_reset_mid();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
